div_sign_fix_hilo: RTL and testbench
====================================

# div_sign_fix_hilo

Writeback stage directly downstream of the 32-bit restoring divider core. It accepts the core's unsigned quotient/remainder magnitudes plus operand-sign sideband over a valid/ready handshake and applies signed (truncating) correction. It commits the results into the architectural HI (remainder) and LO (quotient) registers and reports divide-by-zero. It also owns the mthi/mtlo write path.

## Interface
- WIDTH, 32, datapath width of quotient, remainder and HI/LO

- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous, active-high reset
- res_valid  in  1  divider core result valid
- res_ready  out  1  stage can accept a result
- quot_mag  in  WIDTH  unsigned quotient magnitude from core
- rem_mag  in  WIDTH+1  core remainder; bits [WIDTH-1:0] used, bit WIDTH ignored
- is_signed  in  1  1 = div (signed), 0 = divu
- dividend_sign  in  1  sign bit of original dividend
- divisor_sign  in  1  sign bit of original divisor
- div_zero  in  1  divisor was zero
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wr_data  in  WIDTH  mthi/mtlo data
- hi_q  out  WIDTH  HI register (remainder)
- lo_q  out  WIDTH  LO register (quotient)
- done  out  1  one-cycle pulse: result committed
- dz_flag  out  1  last accepted result was divide-by-zero

## Operation
- FSM states: IDLE, FIX, COMMIT.
  - IDLE: res_ready=1. A handshake (res_valid & res_ready) captures quot_mag, rem_mag[WIDTH-1:0] and all sideband. Next state is FIX.
  - FIX: compute signed results into registers. Next state is COMMIT unconditionally.
  - COMMIT: write HI/LO and pulse done. Next state is IDLE.
- res_ready = (state == IDLE). res_valid is ignored outside IDLE; the core holds its data until accepted.
- Quotient is negated iff is_signed & (dividend_sign ^ divisor_sign).
- Remainder is negated iff is_signed & dividend_sign (remainder takes the dividend's sign).
- Negation is two's complement modulo 2^WIDTH. -2^31 / -1 gives quot_mag 0x80000000, which commits as LO=0x80000000 with no flag.
- Divide-by-zero (captured div_zero=1):
  - HI and LO keep their prior values.
  - dz_flag is set at the COMMIT edge.
  - done still pulses.
- dz_flag is updated only at each COMMIT edge (set to the captured div_zero) and by clr.
- mthi/mtlo: hi_we/lo_we write wr_data to HI/LO on the edge in any state.
  - If hi_we coincides with the COMMIT edge, the hi_we write wins for HI; LO still takes the quotient. The same rule applies symmetrically to lo_we.
  - The external write is later in program order, so it has priority.
- clr in any state:
  - Next state is IDLE.
  - hi_q, lo_q, dz_flag and done are cleared to 0.
  - Any in-flight result is discarded and no done pulse is issued.
  - clr has priority over hi_we/lo_we.

## Timing
- Reset values: hi_q=0, lo_q=0, done=0, dz_flag=0. res_ready=1 the cycle after clr.
- Edge E0: handshake in IDLE. Registers capture the inputs.
- Edge E1: FIX registers the signed results.
- Edge E2: COMMIT writes HI/LO. done=1 for exactly the cycle following E2. State is back in IDLE with res_ready=1 in that same cycle.
- Latency: handshake to HI/LO visible is 2 edges. Throughput is one result per 3 cycles.
- A back-to-back result offered with res_valid held high is accepted at E3.
- hi_q/lo_q are registered outputs with no combinational path from inputs.
- done and dz_flag are registered.

## Test plan
- Unsigned 100/7: quot_mag=14, rem_mag=2, is_signed=0 -> at E2, LO=0x0000000E and HI=0x00000002; done high for one cycle; dz_flag=0.
- Signed -100/7: same magnitudes, dividend_sign=1, divisor_sign=0 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- Signed 100/-7 and -100/-7:
  - 100/-7 -> LO=0xFFFFFFF2, HI=0x00000002.
  - -100/-7 -> LO=0x0000000E, HI=0xFFFFFFFE.
  - Also run -2^31/-1 (quot_mag=0x80000000) -> LO=0x80000000.
- Divide-by-zero: preload HI=0x11, LO=0x22 via hi_we/lo_we; offer div_zero=1 -> HI/LO unchanged, dz_flag=1 after E2, done pulses. A following valid 9/3 -> LO=3, HI=0, dz_flag=0.
- Collision: hi_we=1 with wr_data=0x0000ABCD on the COMMIT edge of 100/7 -> HI=0x0000ABCD, LO=0x0000000E. Hold res_valid high throughout -> second accept occurs at E3, not earlier.
- clr asserted in FIX -> next cycle state IDLE, res_ready=1, hi_q=lo_q=0, dz_flag=0, no done pulse ever for the discarded result.

Source files
------------

// File: rtl/div_sign_fix_hilo.sv
// Divider writeback stage: applies truncating signed correction to the core's magnitudes
// and commits them to HI (remainder) / LO (quotient); also owns the mthi/mtlo write path.
module div_sign_fix_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] quot_mag,
  input  logic [WIDTH:0]   rem_mag,
  input  logic             is_signed,
  input  logic             dividend_sign,
  input  logic             divisor_sign,
  input  logic             div_zero,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             done,
  output logic             dz_flag
);

  typedef enum logic [1:0] {StIdle, StFix, StCommit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             done_d, dz_flag_d;

  // The core's remainder carries a spare top bit that this stage never needs.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_mag[WIDTH];

  always_comb begin
    state_d    = state_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dz_flag_d  = dz_flag;
    done_d     = 1'b0;
    res_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        res_ready = 1'b1;
        if (res_valid) begin
          quot_d     = quot_mag;
          rem_d      = rem_mag[WIDTH-1:0];
          neg_quot_d = is_signed & (dividend_sign ^ divisor_sign);
          neg_rem_d  = is_signed & dividend_sign;
          dz_d       = div_zero;
          state_d    = StFix;
        end
      end
      StFix: begin
        // Two's complement wraps, so -2^31 / -1 naturally commits 0x80000000.
        if (neg_quot_q) quot_d = -quot_q;
        if (neg_rem_q)  rem_d  = -rem_q;
        state_d = StCommit;
      end
      StCommit: begin
        if (!dz_q) begin
          hi_d = rem_q;
          lo_d = quot_q;
        end
        dz_flag_d = dz_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // mthi/mtlo are younger in program order than the divide, so they win.
    if (hi_we) hi_d = wr_data;
    if (lo_we) lo_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done       <= 1'b0;
      dz_flag    <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done       <= done_d;
      dz_flag    <= dz_flag_d;
    end
  end

endmodule

// File: tb/tb_div_sign_fix_hilo.sv
// Directed bench for div_sign_fix_hilo: sign correction, div-by-zero, mthi/mtlo collision,
// back-to-back acceptance and clr while a result is in flight.
module tb_div_sign_fix_hilo;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             clr;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quot_mag;
  logic [WIDTH:0]   rem_mag;
  logic             is_signed;
  logic             dividend_sign;
  logic             divisor_sign;
  logic             div_zero;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done;
  logic             dz_flag;

  int n_checks = 0;
  int n_fail   = 0;

  div_sign_fix_hilo #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .clr          (clr),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .quot_mag     (quot_mag),
    .rem_mag      (rem_mag),
    .is_signed    (is_signed),
    .dividend_sign(dividend_sign),
    .divisor_sign (divisor_sign),
    .div_zero     (div_zero),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .wr_data      (wr_data),
    .hi_q         (hi_q),
    .lo_q         (lo_q),
    .done         (done),
    .dz_flag      (dz_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic sg,
                        input logic dsg, input logic vsg, input logic dz);
    quot_mag      = q;
    rem_mag       = {1'b1, r};  // spare top bit set so any leakage would show
    is_signed     = sg;
    dividend_sign = dsg;
    divisor_sign  = vsg;
    div_zero      = dz;
  endtask

  // Offer one result, then step through E0..E2 and check the committed values.
  task automatic run_div(input string name, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                         input logic sg, input logic dsg, input logic vsg, input logic dz,
                         input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                         input logic exp_dz);
    set_op(q, r, sg, dsg, vsg, dz);
    res_valid = 1'b1;
    tick();  // E0
    res_valid = 1'b0;
    tick();  // E1
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL %s early_done: got %b want 0", name, done); n_fail++;
    end
    tick();  // E2
    n_checks++;
    if (lo_q !== exp_lo) begin
      $display("FAIL %s lo: got %h want %h", name, lo_q, exp_lo); n_fail++;
    end
    n_checks++;
    if (hi_q !== exp_hi) begin
      $display("FAIL %s hi: got %h want %h", name, hi_q, exp_hi); n_fail++;
    end
    n_checks++;
    if (done !== 1'b1 || res_ready !== 1'b1) begin
      $display("FAIL %s done_ready: got done=%b ready=%b want 1 1", name, done, res_ready);
      n_fail++;
    end
    n_checks++;
    if (dz_flag !== exp_dz) begin
      $display("FAIL %s dz_flag: got %b want %b", name, dz_flag, exp_dz); n_fail++;
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL %s done_width: got %b want 0", name, done); n_fail++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    n_checks++;
    if (hi_q !== 32'h0 || lo_q !== 32'h0) begin
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0 0", hi_q, lo_q); n_fail++;
    end
    n_checks++;
    if (done !== 1'b0 || dz_flag !== 1'b0 || res_ready !== 1'b1) begin
      $display("FAIL reset_ctrl: got done=%b dz=%b ready=%b want 0 0 1", done, dz_flag, res_ready);
      n_fail++;
    end
  endtask

  task automatic test_unsigned();
    // Sign sideband set but is_signed=0: must be ignored.
    run_div("divu_100_7", 32'd14, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_000E,
            1'b0);
  endtask

  task automatic test_signed();
    run_div("div_m100_7", 32'd14, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2,
            1'b0);
    run_div("div_100_m7", 32'd14, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'hFFFF_FFF2,
            1'b0);
    run_div("div_m100_m7", 32'd14, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000E,
            1'b0);
    run_div("div_min_m1", 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000,
            32'h8000_0000, 1'b0);
  endtask

  task automatic test_div_zero();
    wr_data = 32'h11; hi_we = 1'b1;
    tick();
    hi_we = 1'b0; wr_data = 32'h22; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    n_checks++;
    if (hi_q !== 32'h11 || lo_q !== 32'h22) begin
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want 11 22", hi_q, lo_q); n_fail++;
    end
    run_div("div_zero", 32'h5, 32'h7, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 1'b1);
    // dz_flag must hold until the next commit.
    set_op(32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    n_checks++;
    if (dz_flag !== 1'b1) begin
      $display("FAIL dz_hold: got %b want 1", dz_flag); n_fail++;
    end
    tick();
    n_checks++;
    if (lo_q !== 32'd3 || hi_q !== 32'd0 || dz_flag !== 1'b0 || done !== 1'b1) begin
      $display("FAIL divu_9_3: got lo=%h hi=%h dz=%b done=%b want 3 0 0 1", lo_q, hi_q, dz_flag,
               done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_op(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    res_valid = 1'b1;
    tick();  // E0
    tick();  // E1
    n_checks++;
    if (res_ready !== 1'b0) begin
      $display("FAIL b2b_ready_commit: got %b want 0", res_ready); n_fail++;
    end
    hi_we = 1'b1; wr_data = 32'h0000_ABCD;
    tick();  // E2: collision with mthi
    hi_we = 1'b0;
    n_checks++;
    if (hi_q !== 32'h0000_ABCD || lo_q !== 32'h0000_000E) begin
      $display("FAIL collision: got hi=%h lo=%h want 0000abcd 0000000e", hi_q, lo_q); n_fail++;
    end
    n_checks++;
    if (done !== 1'b1 || res_ready !== 1'b1) begin
      $display("FAIL collision_done: got done=%b ready=%b want 1 1", done, res_ready); n_fail++;
    end
    tick();  // E3: second accept
    n_checks++;
    if (res_ready !== 1'b0 || done !== 1'b0) begin
      $display("FAIL b2b_accept_e3: got ready=%b done=%b want 0 0", res_ready, done); n_fail++;
    end
    res_valid = 1'b0;
    tick();  // E4
    n_checks++;
    if (hi_q !== 32'h0000_ABCD || done !== 1'b0) begin
      $display("FAIL b2b_not_early: got hi=%h done=%b want 0000abcd 0", hi_q, done); n_fail++;
    end
    tick();  // E5
    n_checks++;
    if (hi_q !== 32'h2 || lo_q !== 32'hE || done !== 1'b1) begin
      $display("FAIL b2b_second: got hi=%h lo=%h done=%b want 2 e 1", hi_q, lo_q, done); n_fail++;
    end
    tick();
  endtask

  task automatic test_clr_in_fix();
    wr_data = 32'h55; hi_we = 1'b1; lo_we = 1'b1;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    set_op(32'd14, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    res_valid = 1'b1;
    tick();  // E0, now in FIX
    res_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (res_ready !== 1'b1 || hi_q !== 32'h0 || lo_q !== 32'h0 || dz_flag !== 1'b0) begin
      $display("FAIL clr_fix: got ready=%b hi=%h lo=%h dz=%b want 1 0 0 0", res_ready, hi_q, lo_q,
               dz_flag);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (done !== 1'b0 || lo_q !== 32'h0) begin
        $display("FAIL clr_no_done[%0d]: got done=%b lo=%h want 0 0", i, done, lo_q); n_fail++;
      end
      tick();
    end
  endtask

  initial begin
    clr = 1'b1; res_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    set_op('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_clr_in_fix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
